downstream_order_gateway: RTL

- Feeds `upstream_processor_top` from the order-entry side: the writer/initiator for its `new_order`/`new_max` strobe interface.
- Buffers incoming order and limit requests in a small FIFO.
- For each order, reads the client's `accumulated_orders` and `max_to_trade` from the upstream block, then risk-checks `accumulated + amount <= max`.
- On pass, issues a one-cycle `new_order` write. Limit requests are forwarded as `new_max` writes. Every request gets an accept/reject response.

---
 rtl/order_gw_pkg.sv | 21 ++
 rtl/order_req_fifo.sv | 49 ++++
 rtl/downstream_order_gateway.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/order_gw_pkg.sv
// Shared types for downstream_order_gateway: FSM states, response reasons, request record.
package order_gw_pkg;
  localparam int GW_CLIENT_W = 5;
  localparam int GW_AMT_W    = 32;
  localparam int GW_CNT_W    = 8;

  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, RESP, SETTLE} gw_state_e;

  typedef enum logic [1:0] {
    OK       = 2'd0,
    LIMIT    = 2'd1,
    ZERO     = 2'd2,
    OVERFLOW = 2'd3
  } gw_reason_e;

  typedef struct packed {
    logic                   is_max;
    logic [GW_CLIENT_W-1:0] client_id;
    logic [GW_AMT_W-1:0]    amount;
  } order_req_t;
endpackage

// File: rtl/order_req_fifo.sv
// Synchronous request FIFO, no bypass; DEPTH must be a power of two so pointers wrap naturally.
module order_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q + AW'(do_push);
    rptr_d = rptr_q + AW'(do_pop);
    cnt_d  = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end
endmodule

// File: rtl/downstream_order_gateway.sv
// Order-entry gateway: queues order/limit requests, risk-checks orders against upstream state,
// issues new_order/new_max strobes. ORDER_GATEWAY_STATS_EN adds accept/reject counters.
module downstream_order_gateway
  import order_gw_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int READ_LAT   = 2,
  parameter int SETTLE_CYC = 3,
  parameter int CLIENT_W   = GW_CLIENT_W,
  parameter int AMT_W      = GW_AMT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CLIENT_W-1:0] req_client_id,
  input  logic [AMT_W-1:0]    req_amount,
  input  logic                req_is_max,
  output logic [CLIENT_W-1:0] client_id,
  output logic [AMT_W-1:0]    amount,
  output logic                new_order,
  output logic                new_max,
  input  logic [AMT_W-1:0]    accumulated_orders,
  input  logic [AMT_W-1:0]    max_to_trade,
  output logic                resp_valid,
  output logic                resp_accept,
  output logic [1:0]          resp_reason,
  output logic [CLIENT_W-1:0] resp_client_id,
  output logic                busy
`ifdef ORDER_GATEWAY_STATS_EN
  ,
  output logic [31:0]         stat_accepted,
  output logic [31:0]         stat_rejected
`endif
);
  localparam int REQ_W = $bits(order_req_t);

  order_req_t    push_rec, head, hold_q;
  logic [REQ_W-1:0] fifo_dout;
  logic          fifo_full, fifo_empty, fifo_pop;

  gw_state_e     state_q;
  logic [GW_CNT_W-1:0] cnt_q;
  logic [CLIENT_W-1:0] client_id_q, resp_client_id_q;
  logic [AMT_W-1:0]    amount_q;
  logic          new_order_q, new_max_q, resp_valid_q, resp_accept_q;
  gw_reason_e    resp_reason_q;

  logic [AMT_W:0] sum;
  gw_reason_e     dec_reason;

  assign push_rec = '{is_max: req_is_max, client_id: req_client_id, amount: req_amount};
  assign head     = order_req_t'(fifo_dout);
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  order_req_fifo #(.DEPTH(FIFO_DEPTH), .W(REQ_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .din   (push_rec),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Priority: zero amount, then carry-out, then limit.
  always_comb begin
    sum        = {1'b0, accumulated_orders} + {1'b0, hold_q.amount};
    dec_reason = OK;
    if (hold_q.amount == '0)              dec_reason = ZERO;
    else if (sum[AMT_W])                  dec_reason = OVERFLOW;
    else if (sum[AMT_W-1:0] > max_to_trade) dec_reason = LIMIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      hold_q           <= '0;
      cnt_q            <= '0;
      client_id_q      <= '0;
      amount_q         <= '0;
      new_order_q      <= 1'b0;
      new_max_q        <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_accept_q    <= 1'b0;
      resp_reason_q    <= OK;
      resp_client_id_q <= '0;
    end else begin
      new_order_q  <= 1'b0;
      new_max_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (!fifo_empty) begin
          hold_q      <= head;
          client_id_q <= head.client_id;
          amount_q    <= head.amount;
          cnt_q       <= GW_CNT_W'(READ_LAT - 1);
          // Limits skip the lookup but still take the CHECK cycle, landing their response two cycles after the push.
          state_q     <= head.is_max ? CHECK : LOOKUP;
        end
        LOOKUP: begin
          if (cnt_q == '0) state_q <= CHECK;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        CHECK: begin
          resp_valid_q     <= 1'b1;
          resp_client_id_q <= hold_q.client_id;
          if (hold_q.is_max) begin
            resp_accept_q <= 1'b1;
            resp_reason_q <= OK;
            new_max_q     <= 1'b1;
          end else begin
            resp_accept_q <= (dec_reason == OK);
            resp_reason_q <= dec_reason;
            new_order_q   <= (dec_reason == OK);
          end
          state_q <= RESP;
        end
        RESP: begin
          if (resp_accept_q) begin
            cnt_q   <= GW_CNT_W'(SETTLE_CYC - 1);
            state_q <= SETTLE;
          end else begin
            state_q <= IDLE;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = !fifo_full;
  assign client_id      = client_id_q;
  assign amount         = amount_q;
  assign new_order      = new_order_q;
  assign new_max        = new_max_q;
  assign resp_valid     = resp_valid_q;
  assign resp_accept    = resp_accept_q;
  assign resp_reason    = resp_reason_q;
  assign resp_client_id = resp_client_id_q;
  assign busy           = (state_q != IDLE) || !fifo_empty;

`ifdef ORDER_GATEWAY_STATS_EN
  logic [31:0] stat_acc_q, stat_acc_d, stat_rej_q, stat_rej_d;

  always_comb begin
    stat_acc_d = stat_acc_q;
    stat_rej_d = stat_rej_q;
    if (resp_valid_q && resp_accept_q && (stat_acc_q != '1))  stat_acc_d = stat_acc_q + 32'd1;
    if (resp_valid_q && !resp_accept_q && (stat_rej_q != '1)) stat_rej_d = stat_rej_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_acc_q <= '0;
      stat_rej_q <= '0;
    end else begin
      stat_acc_q <= stat_acc_d;
      stat_rej_q <= stat_rej_d;
    end
  end

  assign stat_accepted = stat_acc_q;
  assign stat_rejected = stat_rej_q;
`endif
endmodule
